// File: rtl/sci_pkg.sv
// Shared constants and types for the single-cycle MIPS subset core.
package sci_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation selector
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_SLTU = 3'd5,
        ALU_SRL  = 3'd6
    } alu_ctrl_e;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/sci_alu.sv
// Combinational ALU with zero flag.
module sci_alu
    import sci_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic [2:0]  ctrl,
    output logic [31:0] res,
    output logic        zero
);

    // Select the operation; shifts act on the b operand (rt)
    always_comb begin
        res = 32'd0;
        case (alu_ctrl_e'(ctrl))
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_SLT:  res = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: res = {31'd0, a < b};
            ALU_SRL:  res = b >> shamt;
            default:  res = 32'd0;
        endcase
    end

    assign zero = (res == 32'd0);

endmodule

// File: rtl/sci_mem.sv
// Generic word-addressed memory: combinational read, write on rising edge.
// Contents have no reset; they are preloaded before reset is released.
module sci_mem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:WORDS-1];

    assign rdata = mem[addr];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sci_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port.
// Register $0 is hardwired to zero.
module sci_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regfile [0:31];

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regfile[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regfile[raddr2];

    // Clear on reset; otherwise commit one write per cycle, dropping writes to $0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regfile[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regfile[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/sci_mips_core.sv
// Single-cycle MIPS subset core: fetch, decode, execute and retire one
// instruction per clock. Memories are preloaded externally.
module sci_mips_core
    import sci_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] instruction;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] imm_sext;

    // Control
    logic        reg_write;
    logic        reg_dst_rd;
    logic        link;
    logic        alu_src_imm;
    alu_ctrl_e   alu_ctrl;
    logic        mem_write;
    logic        mem_to_reg;
    logic        load_half;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;

    // Datapath
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic [31:0] dmem_rdata;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        branch_taken;

    assign opcode   = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign shamt    = instruction[10:6];
    assign funct    = instruction[5:0];
    assign imm      = instruction[15:0];
    assign target   = instruction[25:0];
    assign imm_sext = sext16(imm);

    sci_mem #(.WORDS(IMEM_WORDS)) imem (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc_curr[IMEM_AW+1:2]),
        .wdata (32'd0),
        .rdata (instruction)
    );

    // Decode opcode/funct into datapath controls; unknown encodings do nothing
    always_comb begin
        reg_write   = 1'b0;
        reg_dst_rd  = 1'b0;
        link        = 1'b0;
        alu_src_imm = 1'b0;
        alu_ctrl    = ALU_ADD;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        load_half   = 1'b0;
        branch_eq   = 1'b0;
        branch_ne   = 1'b0;
        jump        = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst_rd = 1'b1;
                case (funct)
                    FN_ADD: begin reg_write = 1'b1; alu_ctrl = ALU_ADD; end
                    FN_SUB: begin reg_write = 1'b1; alu_ctrl = ALU_SUB; end
                    FN_AND: begin reg_write = 1'b1; alu_ctrl = ALU_AND; end
                    FN_OR:  begin reg_write = 1'b1; alu_ctrl = ALU_OR;  end
                    FN_SLT: begin reg_write = 1'b1; alu_ctrl = ALU_SLT; end
                    FN_SRL: begin reg_write = 1'b1; alu_ctrl = ALU_SRL; end
                    default: ;
                endcase
            end
            OP_LW: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                mem_to_reg  = 1'b1;
            end
            OP_LHU: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                mem_to_reg  = 1'b1;
                load_half   = 1'b1;
            end
            OP_SW: begin
                alu_src_imm = 1'b1;
                mem_write   = 1'b1;
            end
            OP_SLTIU: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_ctrl    = ALU_SLTU;
            end
            OP_BEQ: begin
                alu_ctrl  = ALU_SUB;
                branch_eq = 1'b1;
            end
            OP_BNE: begin
                alu_ctrl  = ALU_SUB;
                branch_ne = 1'b1;
            end
            OP_J: begin
                jump = 1'b1;
            end
            OP_JAL: begin
                jump      = 1'b1;
                link      = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    sci_regfile RegFile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_data),
        .rdata2 (rt_data),
        .we     (reg_write),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    assign alu_b = alu_src_imm ? imm_sext : rt_data;

    sci_alu ALU (
        .a     (rs_data),
        .b     (alu_b),
        .shamt (shamt),
        .ctrl  (alu_ctrl),
        .res   (alu_res),
        .zero  (alu_zero)
    );

    // Store is suppressed while reset is held so an aborted instruction leaves memory intact
    sci_mem #(.WORDS(DMEM_WORDS)) DMEM (
        .clk   (clk),
        .we    (mem_write & reset),
        .addr  (alu_res[DMEM_AW+1:2]),
        .wdata (rt_data),
        .rdata (dmem_rdata)
    );

    assign wb_addr = link ? 5'd31 : (reg_dst_rd ? rd : rt);

    // Writeback source: return address, halfword load, word load or ALU result
    always_comb begin
        wb_data = alu_res;
        if (link) begin
            wb_data = pc_plus4;
        end else if (load_half) begin
            wb_data = {16'd0, alu_res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0]};
        end else if (mem_to_reg) begin
            wb_data = dmem_rdata;
        end
    end

    assign pc_plus4     = pc_curr + 32'd4;
    assign branch_taken = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);

    // Next PC: jump, taken branch, or sequential
    always_comb begin
        pc_next = pc_plus4;
        if (jump) begin
            pc_next = {pc_plus4[31:28], target, 2'b00};
        end else if (branch_taken) begin
            pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
        end
    end

    // Program counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_curr <= RESET_PC;
        end else begin
            pc_curr <= pc_next;
        end
    end

endmodule

// File: tb/tb_sci_mips_core.sv
// Self-checking bench for sci_mips_core: an instruction-level model runs in
// lockstep with the core and the architectural state is compared every cycle.
module tb_sci_mips_core;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Instruction-level model state
    logic [31:0] m_pc;
    logic [31:0] m_regs [0:31];
    logic [31:0] m_imem [0:255];
    logic [31:0] m_dmem [0:255];

    sci_mips_core dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    // ---------------- encoding helpers ----------------
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_word(input int i, input logic [31:0] iw, input logic [31:0] dw);
        dut.imem.mem[i] = iw;
        m_imem[i]       = iw;
        dut.DMEM.mem[i] = dw;
        m_dmem[i]       = dw;
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, se, addr, npc, w;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wv;
        ins  = m_imem[m_pc[9:2]];
        op   = ins[31:26];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        fn   = ins[5:0];
        a    = m_regs[rs];
        b    = m_regs[rt];
        se   = {{16{ins[15]}}, ins[15:0]};
        addr = a + se;
        npc  = m_pc + 32'd4;
        wr   = 1'b0;
        wa   = 5'd0;
        wv   = 32'h0;
        case (op)
            6'h00: begin
                wr = 1'b1;
                wa = rd;
                case (fn)
                    6'h20: wv = a + b;
                    6'h22: wv = a - b;
                    6'h24: wv = a & b;
                    6'h25: wv = a | b;
                    6'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h02: wv = b >> sh;
                    default: wr = 1'b0;
                endcase
            end
            6'h23: begin wr = 1'b1; wa = rt; wv = m_dmem[addr[9:2]]; end
            6'h25: begin
                w  = m_dmem[addr[9:2]];
                wr = 1'b1;
                wa = rt;
                wv = addr[1] ? (w >> 16) : (w & 32'h0000_FFFF);
            end
            6'h2B: m_dmem[addr[9:2]] = b;
            6'h0B: begin wr = 1'b1; wa = rt; wv = (a < se) ? 32'd1 : 32'd0; end
            6'h04: if (a == b) npc = m_pc + 32'd4 + (se << 2);
            6'h05: if (a != b) npc = m_pc + 32'd4 + (se << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            6'h03: begin
                wr  = 1'b1;
                wa  = 5'd31;
                wv  = m_pc + 32'd4;
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
        if (wr && wa != 5'd0) m_regs[wa] = wv;
        m_pc = npc;
    endtask

    // ---------------- per-cycle compare ----------------
    // Reset only changes just after a falling edge, so the level seen here
    // tells whether the rising edge that just passed retired an instruction.
    always @(negedge clk) begin
        int bad;
        logic [31:0] cur;
        if (!reset) model_reset();
        else        model_step();

        check_eq("pc_curr", dut.pc_curr, m_pc);
        check_eq("instruction", dut.instruction, m_imem[m_pc[9:2]]);

        bad = -1;
        for (int i = 0; i < 32; i++)
            if (bad < 0 && dut.RegFile.regfile[i] !== m_regs[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL regfile[%0d] at pc %h: got %h, expected %h",
                     bad, m_pc, dut.RegFile.regfile[bad], m_regs[bad]);
        end

        bad = -1;
        for (int i = 0; i < 256; i++)
            if (bad < 0 && dut.DMEM.mem[i] !== m_dmem[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL dmem[%0d] at pc %h: got %h, expected %h",
                     bad, m_pc, dut.DMEM.mem[bad], m_dmem[bad]);
        end

        cur = m_imem[m_pc[9:2]];
        if (reset && (cur[31:26] == 6'h04 || cur[31:26] == 6'h05))
            check_eq("alu_zero_branch", {31'd0, dut.ALU.zero},
                     {31'd0, m_regs[cur[25:21]] == m_regs[cur[20:16]]});
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] im;
        logic [5:0]  fn;
        int k;
        rs = 5'($urandom_range(0, 31));
        rt = 5'($urandom_range(0, 31));
        rd = 5'($urandom_range(0, 31));
        sh = 5'($urandom_range(0, 31));
        im = 16'($urandom);
        k  = $urandom_range(0, 11);
        case (k)
            0, 1, 2: begin
                case ($urandom_range(0, 7))
                    0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
                    4: fn = 6'h2A; 5: fn = 6'h02; 6: fn = 6'h21; default: fn = 6'h00;
                endcase
                return enc_r(rs, rt, rd, sh, fn);
            end
            3: return enc_i(6'h23, rs, rt, im);
            4: return enc_i(6'h2B, rs, rt, im);
            5: return enc_i(6'h25, rs, rt, im);
            6: return enc_i(6'h0B, rs, rt, im);
            7: return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 15)) - 16'd8);
            8: return enc_i(6'h05, rs, rt, 16'($urandom_range(0, 15)) - 16'd8);
            9: return enc_j(($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03, 26'($urandom));
            10: return {6'h3F, 26'($urandom)};
            default: return {6'h08, rs, rt, im};
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        // Directed program; words 2..9 of data memory hold operands
        for (int i = 0; i < 256; i++) load_word(i, 32'h0, 32'h0);
        load_word(2, 32'h0, 32'hABCD_1234);
        load_word(3, 32'h0, 32'd5);
        load_word(4, 32'h0, 32'd3);
        load_word(5, 32'h0, 32'h0000_F0F0);
        load_word(6, 32'h0, 32'h0000_0FF0);
        load_word(7, 32'h0, 32'hFFFF_FFFF);
        load_word(8, 32'h0, 32'd1);
        load_word(9, 32'h0, 32'h8000_0000);
        begin
            logic [31:0] prog [0:25];
            prog[0]  = enc_i(6'h23, 0, 8, 16'd12);      // lw   $t0,12($0)
            prog[1]  = enc_i(6'h23, 0, 9, 16'd16);      // lw   $t1,16($0)
            prog[2]  = enc_i(6'h04, 8, 8, 16'd1);       // beq  $t0,$t0,+1
            prog[3]  = enc_r(8, 8, 23, 0, 6'h20);       // add  $s7 (skipped)
            prog[4]  = enc_j(6'h03, 26'd8);             // jal  0x20
            prog[5]  = enc_i(6'h05, 8, 8, 16'd1);       // bne  $t0,$t0,+1
            prog[6]  = {6'h3F, 26'h0123456};            // unknown opcode
            prog[7]  = enc_j(6'h02, 26'd7);             // j    self
            prog[8]  = enc_r(8, 9, 10, 0, 6'h20);       // add  $t2
            prog[9]  = enc_r(8, 9, 11, 0, 6'h22);       // sub  $t3
            prog[10] = enc_i(6'h23, 0, 14, 16'd20);     // lw   $t6
            prog[11] = enc_i(6'h23, 0, 15, 16'd24);     // lw   $t7
            prog[12] = enc_r(14, 15, 16, 0, 6'h24);     // and  $s0
            prog[13] = enc_r(14, 15, 17, 0, 6'h25);     // or   $s1
            prog[14] = enc_i(6'h23, 0, 12, 16'd28);     // lw   $t4 = -1
            prog[15] = enc_i(6'h23, 0, 13, 16'd32);     // lw   $t5 = 1
            prog[16] = enc_r(12, 13, 2, 0, 6'h2A);      // slt  $v0
            prog[17] = enc_i(6'h2B, 0, 10, 16'd4);      // sw   $t2,4($0)
            prog[18] = enc_i(6'h23, 0, 12, 16'd4);      // lw   $t4,4($0)
            prog[19] = enc_i(6'h25, 0, 20, 16'd8);      // lhu  $s4,8($0)
            prog[20] = enc_i(6'h25, 0, 21, 16'd10);     // lhu  $s5,10($0)
            prog[21] = enc_i(6'h0B, 8, 19, 16'hFFFF);   // sltiu $s3,$t0,-1
            prog[22] = enc_i(6'h23, 0, 18, 16'd36);     // lw   $s2
            prog[23] = enc_r(0, 18, 18, 4, 6'h02);      // srl  $s2,$s2,4
            prog[24] = enc_r(8, 9, 0, 0, 6'h20);        // add  $0 (discarded)
            prog[25] = enc_j(6'h02, 26'd5);             // j    0x14
            for (int i = 0; i < 26; i++) begin
                dut.imem.mem[i] = prog[i];
                m_imem[i]       = prog[i];
            end
        end

        #22 reset = 1'b1;
        @(negedge clk); #1;
        check_eq("pc_after_first_edge", dut.pc_curr, 32'h4);
        @(negedge clk); #1;
        check_eq("pc_seq", dut.pc_curr, 32'h8);
        check_eq("beq_zero", {31'd0, dut.ALU.zero}, 32'd1);
        @(negedge clk); #1;
        check_eq("beq_target", dut.pc_curr, 32'h10);
        @(negedge clk); #1;
        check_eq("jal_target", dut.pc_curr, 32'h20);
        check_eq("jal_ra", dut.RegFile.regfile[31], 32'h14);
        repeat (18) @(negedge clk);
        #1;
        check_eq("j_back", dut.pc_curr, 32'h14);
        check_eq("bne_zero", {31'd0, dut.ALU.zero}, 32'd1);
        @(negedge clk); #1;
        check_eq("bne_fallthrough", dut.pc_curr, 32'h18);
        repeat (5) @(negedge clk);
        #1;
        check_eq("loop_pc", dut.pc_curr, 32'h1C);
        check_eq("model_t2", m_regs[10], 32'd8);
        check_eq("model_t3", m_regs[11], 32'd2);
        check_eq("t2_add", dut.RegFile.regfile[10], 32'd8);
        check_eq("t3_sub", dut.RegFile.regfile[11], 32'd2);
        check_eq("s0_and", dut.RegFile.regfile[16], 32'h0000_00F0);
        check_eq("s1_or", dut.RegFile.regfile[17], 32'h0000_FFF0);
        check_eq("v0_slt", dut.RegFile.regfile[2], 32'd1);
        check_eq("mem1_sw", dut.DMEM.mem[1], 32'd8);
        check_eq("t4_lw", dut.RegFile.regfile[12], 32'd8);
        check_eq("s4_lhu_lo", dut.RegFile.regfile[20], 32'h0000_1234);
        check_eq("s5_lhu_hi", dut.RegFile.regfile[21], 32'h0000_ABCD);
        check_eq("s3_sltiu", dut.RegFile.regfile[19], 32'd1);
        check_eq("s2_srl", dut.RegFile.regfile[18], 32'h0800_0000);
        check_eq("s7_skipped", dut.RegFile.regfile[23], 32'd0);
        check_eq("r0_zero", dut.RegFile.regfile[0], 32'd0);

        // Random program with random data, including a reset mid-run
        reset = 1'b0;
        for (int i = 0; i < 256; i++) load_word(i, rand_instr(), $urandom);
        @(negedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        repeat (300) @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (300) @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sci_mips_core.md
Name: sci_mips_core

Overview:
- Single-cycle 32-bit MIPS subset processor: one instruction fetched, decoded, executed and retired per clock.
- Contains the PC, instruction memory, register file, ALU and data memory.
- Memories are preloaded via $readmemh before reset is released.
- Top-level block in simulation; its only ports are clock and reset.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_WORDS, 256, data memory depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value while reset is asserted.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.

Behaviour:
- Reset (asynchronous, active-low):
  - pc_curr = RESET_PC; all 32 registers = 0.
  - Memory contents are NOT cleared.
  - Reset mid-operation aborts the current instruction: no register or memory write occurs.
- Fetch:
  - instruction = imem.mem[pc_curr[log2(IMEM_WORDS)+1:2]], combinational.
  - Upper address bits are ignored, so addresses wrap.
- Register file (instance RegFile, array regfile[0:31]):
  - Two combinational read ports; one write port on the rising edge.
  - $0 always reads 0; writes to $0 are discarded.
- ALU (instance ALU): outputs res[31:0] and zero = (res == 0).
- Data memory (instance DMEM, array mem[0:DMEM_WORDS-1] of 32-bit words):
  - Combinational read; write on the rising edge.
  - Word index = addr[log2(DMEM_WORDS)+1:2], wrapping.
- Next PC:
  - Default pc+4.
  - Branch target = pc+4 + (sext(imm16)<<2).
  - Jump target = {pc+4[31:28], target26, 2'b00}.
- R-type (opcode 0x00), result written to rd:
  - ADD 0x20, SUB 0x22: wrap-around arithmetic, no overflow trap.
  - AND 0x24, OR 0x25.
  - SLT 0x2A: signed compare.
  - SRL 0x02: rd = rt >> shamt, logical.
  - Any other funct: no write (NOP).
- LW 0x23: rt = mem[rs+sext(imm)].
- SW 0x2B: mem[rs+sext(imm)] = rt.
- LHU 0x25:
  - rt = zero-extended halfword of the addressed word.
  - addr[1]=0 selects bits [15:0]; addr[1]=1 selects bits [31:16].
- SLTIU 0x0B: rt = (rs < sext(imm)) unsigned ? 1 : 0.
- BEQ 0x04: branch when the ALU rs-rt result has zero=1. BNE 0x05: branch when zero=0.
- J 0x02: jump.
- JAL 0x03: jump and $31 = pc+4.
- Unknown opcode: NOP; pc+4; no register or memory writes.
- Misaligned word accesses ignore addr[1:0].
- Hierarchical names pc_curr, instruction, imem.mem, DMEM.mem, RegFile.regfile, ALU.res and ALU.zero are mandatory; the testbench probes them directly.

Decomposition:
- Package sci_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_SLTIU, OP_LHU);
  - funct constants;
  - the ALU-control enum (ADD, SUB, AND, OR, SLT, SLTU, SRL).
- Sub-modules:
  - sci_regfile (instance RegFile);
  - sci_alu (instance ALU);
  - generic sci_mem, instantiated as imem (read-only) and DMEM.
- The control decoder stays inline in the top.

Test Plan:
- Hold reset low 20 ns, then release:
  - during reset, pc_curr = 0 and all regs = 0;
  - the first edge after release fetches imem.mem[0];
  - pc_curr advances by 4 each cycle.
- Preload $t0=5, $t1=3, then ADD $t2 and SUB $t3 → $t2=8, $t3=2; AND/OR of 0xF0F0/0x0FF0 → 0x00F0/0xFFF0; SLT(-1,1) = 1.
- SW $t2 to 4($0), then LW $t4 from 4($0):
  - Mem[1]=8 and $t4=8;
  - with Mem[2]=0xABCD1234, LHU at byte 8 → 0x1234 and at byte 10 → 0xABCD.
- BEQ with equal operands:
  - branches to pc+4+imm*4, ALU.zero=1;
  - BNE with the same operands falls through.
- JAL at pc 0x10:
  - $ra = 0x14; PC = target;
  - J back repeats the loop with no register writes.
- SLTIU $t5,$t0,-1 → 1 (0xFFFFFFFF unsigned). SRL 0x80000000 by 4 → 0x08000000. Unknown opcode 0x3F → NOP.
